// File: rtl/ay_bus_master.sv
// AY-style register bus master: turns single read/write requests into
// select / address / data phases on BDIR/BC/BUS_DO, each followed by an idle gap.
module ay_bus_master #(
  parameter int PHASE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  output logic       REQ_READY,
  input  logic       REQ_RD,
  input  logic       REQ_CHIP,
  input  logic       REQ_FM,
  input  logic [7:0] REQ_ADDR,
  input  logic [7:0] REQ_DATA,
  output logic       RSP_VALID,
  output logic [7:0] RSP_DATA,
  output logic       ERR,
  output logic       BDIR,
  output logic       BC,
  output logic [7:0] BUS_DO,
  input  logic [7:0] BUS_DI,
  output logic       BUSY
);

  typedef enum logic [2:0] {
    S_IDLE, S_SEL, S_ADDR, S_WR, S_RD, S_GAP, S_RESP
  } state_t;

  localparam logic [7:0] PHASE_LD = 8'(PHASE_CYC - 1);
  localparam logic [7:0] GAP_LD   = 8'(GAP_CYC - 1);

  state_t     state_q, state_d;
  state_t     gap_nxt_q, gap_nxt_d;
  logic [7:0] cnt_q, cnt_d;
  logic       sel_valid_q, sel_valid_d;
  logic       cur_chip_q, cur_chip_d;
  logic       cur_fm_q, cur_fm_d;
  logic       ready_q, ready_d;
  logic       bdir_q, bdir_d;
  logic       bc_q, bc_d;
  logic [7:0] bus_do_q, bus_do_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       err_q, err_d;

  // Latched request and read sample: data path, not reset
  logic       rd_q, rd_d;
  logic       chip_q, chip_d;
  logic       fm_q, fm_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] samp_q, samp_d;

  logic accept, bad_addr, need_sel, cnt_done;

  always_comb begin
    accept    = REQ_VALID & ready_q;
    bad_addr  = (REQ_ADDR[7:3] == 5'b11111);
    need_sel  = !sel_valid_q || (REQ_CHIP != cur_chip_q) || (REQ_FM != cur_fm_q);
    cnt_done  = (cnt_q == 8'd0);

    state_d     = state_q;
    gap_nxt_d   = gap_nxt_q;
    cnt_d       = cnt_done ? 8'd0 : cnt_q - 8'd1;
    sel_valid_d = sel_valid_q;
    cur_chip_d  = cur_chip_q;
    cur_fm_d    = cur_fm_q;
    err_d       = 1'b0;
    rd_d        = rd_q;
    chip_d      = chip_q;
    fm_d        = fm_q;
    addr_d      = addr_q;
    data_d      = data_q;
    samp_d      = samp_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bad_addr) begin
            err_d = 1'b1;
          end else begin
            rd_d    = REQ_RD;
            chip_d  = REQ_CHIP;
            fm_d    = REQ_FM;
            addr_d  = REQ_ADDR;
            data_d  = REQ_DATA;
            cnt_d   = PHASE_LD;
            state_d = need_sel ? S_SEL : S_ADDR;
          end
        end
      end
      S_SEL: begin
        if (cnt_done) begin
          state_d     = S_GAP;
          cnt_d       = GAP_LD;
          gap_nxt_d   = S_ADDR;
          cur_chip_d  = chip_q;
          cur_fm_d    = fm_q;
          sel_valid_d = 1'b1;
        end
      end
      S_ADDR: begin
        if (cnt_done) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LD;
          gap_nxt_d = rd_q ? S_RD : S_WR;
        end
      end
      S_WR: begin
        if (cnt_done) begin
          state_d   = S_GAP;
          cnt_d     = GAP_LD;
          gap_nxt_d = S_IDLE;
        end
      end
      S_RD: begin
        if (cnt_done) begin
          samp_d    = BUS_DI;
          state_d   = S_GAP;
          cnt_d     = GAP_LD;
          gap_nxt_d = S_RESP;
        end
      end
      S_GAP: begin
        if (cnt_done) begin
          state_d = gap_nxt_q;
          cnt_d   = (gap_nxt_q == S_IDLE || gap_nxt_q == S_RESP) ? 8'd0 : PHASE_LD;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Bus outputs are registered from the next state so they switch only on phase boundaries
    bdir_d   = 1'b0;
    bc_d     = 1'b0;
    bus_do_d = 8'h00;
    unique case (state_d)
      S_SEL:   begin bdir_d = 1'b1; bc_d = 1'b1; bus_do_d = {5'b11111, ~fm_d, 1'b1, chip_d}; end
      S_ADDR:  begin bdir_d = 1'b1; bc_d = 1'b1; bus_do_d = addr_d; end
      S_WR:    begin bdir_d = 1'b1; bc_d = 1'b0; bus_do_d = data_d; end
      S_RD:    begin bdir_d = 1'b0; bc_d = 1'b1; end
      default: ;
    endcase

    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RESP);
    rsp_data_d  = (state_d == S_RESP) ? samp_q : rsp_data_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      gap_nxt_q   <= S_IDLE;
      cnt_q       <= 8'd0;
      sel_valid_q <= 1'b0;
      cur_chip_q  <= 1'b0;
      cur_fm_q    <= 1'b0;
      ready_q     <= 1'b0;
      bdir_q      <= 1'b0;
      bc_q        <= 1'b0;
      bus_do_q    <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gap_nxt_q   <= gap_nxt_d;
      cnt_q       <= cnt_d;
      sel_valid_q <= sel_valid_d;
      cur_chip_q  <= cur_chip_d;
      cur_fm_q    <= cur_fm_d;
      ready_q     <= ready_d;
      bdir_q      <= bdir_d;
      bc_q        <= bc_d;
      bus_do_q    <= bus_do_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge CLK) begin
    rd_q   <= rd_d;
    chip_q <= chip_d;
    fm_q   <= fm_d;
    addr_q <= addr_d;
    data_q <= data_d;
    samp_q <= samp_d;
  end

  assign REQ_READY = ready_q;
  assign BUSY      = ~ready_q;
  assign BDIR      = bdir_q;
  assign BC        = bc_q;
  assign BUS_DO    = bus_do_q;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign ERR       = err_q;

endmodule

// File: tb/tb_ay_bus_master.sv
// Bench for ay_bus_master: two instances (P=4,G=2 and P=1,G=1) checked every cycle
// against a transaction-level model that expands each request into its expected bus trace.
module tb_ay_bus_master;

  typedef struct packed {
    logic       ready;
    logic       bdir;
    logic       bc;
    logic [7:0] dout;
    logic       rsp_v;
    logic [7:0] rsp_d;
    logic       err;
    logic [7:0] di;
  } ent_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       req_valid [2];
  logic       req_rd    [2];
  logic       req_chip  [2];
  logic       req_fm    [2];
  logic [7:0] req_addr  [2];
  logic [7:0] req_data  [2];
  logic [7:0] bus_di    [2];
  logic       req_ready [2];
  logic       rsp_valid [2];
  logic [7:0] rsp_data  [2];
  logic       err       [2];
  logic       bdir      [2];
  logic       bc        [2];
  logic [7:0] bus_do    [2];
  logic       busy      [2];

  ay_bus_master #(.PHASE_CYC(4), .GAP_CYC(2)) dut0 (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid[0]), .REQ_READY(req_ready[0]), .REQ_RD(req_rd[0]),
    .REQ_CHIP(req_chip[0]), .REQ_FM(req_fm[0]), .REQ_ADDR(req_addr[0]), .REQ_DATA(req_data[0]),
    .RSP_VALID(rsp_valid[0]), .RSP_DATA(rsp_data[0]), .ERR(err[0]),
    .BDIR(bdir[0]), .BC(bc[0]), .BUS_DO(bus_do[0]), .BUS_DI(bus_di[0]), .BUSY(busy[0])
  );

  ay_bus_master #(.PHASE_CYC(1), .GAP_CYC(1)) dut1 (
    .CLK(CLK), .RESET(RESET),
    .REQ_VALID(req_valid[1]), .REQ_READY(req_ready[1]), .REQ_RD(req_rd[1]),
    .REQ_CHIP(req_chip[1]), .REQ_FM(req_fm[1]), .REQ_ADDR(req_addr[1]), .REQ_DATA(req_data[1]),
    .RSP_VALID(rsp_valid[1]), .RSP_DATA(rsp_data[1]), .ERR(err[1]),
    .BDIR(bdir[1]), .BC(bc[1]), .BUS_DO(bus_do[1]), .BUS_DI(bus_di[1]), .BUSY(busy[1])
  );

  always #5 CLK = ~CLK;

  // Model state per instance
  logic       sel_valid_m [2];
  logic       cur_chip_m  [2];
  logic       cur_fm_m    [2];
  logic [7:0] last_rsp_m  [2];
  ent_t       qa[$];
  ent_t       qb[$];
  logic       rand_en [2];

  logic       pend_v, pend_rd, pend_chip, pend_fm;
  logic [7:0] pend_addr, pend_data, pend_rdv;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  function automatic ent_t mk(logic ready, logic bd, logic bcc, logic [7:0] dout,
                              logic rv, logic [7:0] rd, logic er);
    ent_t e;
    e.ready = ready; e.bdir = bd; e.bc = bcc; e.dout = dout;
    e.rsp_v = rv; e.rsp_d = rd; e.err = er; e.di = 8'($urandom);
    return e;
  endfunction

  task automatic push(int i, ent_t e);
    if (i == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic phase(int i, int n, logic bd, logic bcc, logic [7:0] dout);
    for (int k = 0; k < n; k++) push(i, mk(1'b0, bd, bcc, dout, 1'b0, last_rsp_m[i], 1'b0));
  endtask

  // Expand one accepted request into the cycle-by-cycle output trace after the accept edge
  task automatic build(int i, logic rd, logic chip, logic fm, logic [7:0] addr,
                       logic [7:0] data, logic [7:0] rdv);
    int   p, g;
    ent_t e;
    p = (i == 0) ? 4 : 1;
    g = (i == 0) ? 2 : 1;
    if (addr[7:3] == 5'h1f) begin
      push(i, mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, last_rsp_m[i], 1'b1));
      return;
    end
    if (!sel_valid_m[i] || chip != cur_chip_m[i] || fm != cur_fm_m[i]) begin
      phase(i, p, 1'b1, 1'b1, {5'h1f, ~fm, 1'b1, chip});
      phase(i, g, 1'b0, 1'b0, 8'h00);
      sel_valid_m[i] = 1'b1;
      cur_chip_m[i]  = chip;
      cur_fm_m[i]    = fm;
    end
    phase(i, p, 1'b1, 1'b1, addr);
    phase(i, g, 1'b0, 1'b0, 8'h00);
    if (rd) begin
      phase(i, p - 1, 1'b0, 1'b1, 8'h00);
      e    = mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b0, last_rsp_m[i], 1'b0);
      e.di = rdv;
      push(i, e);
      phase(i, g, 1'b0, 1'b0, 8'h00);
      last_rsp_m[i] = rdv;
      push(i, mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, rdv, 1'b0));
    end else begin
      phase(i, p, 1'b1, 1'b0, data);
      phase(i, g, 1'b0, 1'b0, 8'h00);
    end
  endtask

  task automatic chk(string nm, int i, logic [7:0] got, logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d cyc%0d: got %0h, expected %0h", nm, i, cyc, got, exp);
    end
  endtask

  // Compare the current outputs of instance i, then drive its inputs for the next edge
  task automatic step(int i);
    ent_t       e;
    logic       rd, chip, fm, v;
    logic [7:0] addr, data, rdv;
    if (i == 0 && qa.size() > 0)      e = qa.pop_front();
    else if (i == 1 && qb.size() > 0) e = qb.pop_front();
    else e = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, last_rsp_m[i], 1'b0);

    chk("ready",     i, 8'(req_ready[i]), 8'(e.ready));
    chk("busy",      i, 8'(busy[i]),      8'(!e.ready));
    chk("bdir",      i, 8'(bdir[i]),      8'(e.bdir));
    chk("bc",        i, 8'(bc[i]),        8'(e.bc));
    chk("bus_do",    i, bus_do[i],        e.dout);
    chk("rsp_valid", i, 8'(rsp_valid[i]), 8'(e.rsp_v));
    chk("rsp_data",  i, rsp_data[i],      e.rsp_d);
    chk("err",       i, 8'(err[i]),       8'(e.err));

    bus_di[i] = e.di;
    rd   = ($urandom_range(0, 3) == 0);
    chip = ($urandom_range(0, 3) == 0) ? ~cur_chip_m[i] : cur_chip_m[i];
    fm   = ($urandom_range(0, 3) == 0) ? ~cur_fm_m[i] : cur_fm_m[i];
    addr = 8'($urandom);
    if ($urandom_range(0, 7) == 0) addr[7:3] = 5'h1f;
    data = 8'($urandom);
    rdv  = 8'($urandom);
    v    = 1'b0;
    if (i == 0 && pend_v) begin
      rd = pend_rd; chip = pend_chip; fm = pend_fm;
      addr = pend_addr; data = pend_data; rdv = pend_rdv;
      v = 1'b1;
      if (e.ready) pend_v = 1'b0;
    end else if (rand_en[i] && (i == 1 || $urandom_range(0, 2) == 0)) begin
      v = 1'b1;
    end
    req_valid[i] = v;
    req_rd[i]    = rd;
    req_chip[i]  = chip;
    req_fm[i]    = fm;
    req_addr[i]  = addr;
    req_data[i]  = data;
    if (v && e.ready) build(i, rd, chip, fm, addr, data, rdv);
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      cyc++;
      step(0);
      step(1);
    end
  endtask

  task automatic send(logic rd, logic chip, logic fm, logic [7:0] addr,
                      logic [7:0] data, logic [7:0] rdv);
    pend_rd = rd; pend_chip = chip; pend_fm = fm;
    pend_addr = addr; pend_data = data; pend_rdv = rdv;
    pend_v = 1'b1;
    for (int k = 0; k < 200 && pend_v; k++) run(1);
    if (pend_v) begin
      n_chk++; n_fail++;
      $display("FAIL accept_timeout inst0 cyc%0d: request not accepted within 200 cycles", cyc);
      pend_v = 1'b0;
    end
  endtask

  task automatic drain(int i);
    int left;
    left = (i == 0) ? qa.size() : qb.size();
    for (int k = 0; k < 500 && left > 0; k++) begin
      run(1);
      left = (i == 0) ? qa.size() : qb.size();
    end
    if (left > 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout inst%0d cyc%0d: %0d cycles left", i, cyc, left);
    end
  endtask

  task automatic chk_reset();
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready",     i, 8'(req_ready[i]), 8'h00);
      chk("rst_bdir",      i, 8'(bdir[i]),      8'h00);
      chk("rst_bc",        i, 8'(bc[i]),        8'h00);
      chk("rst_bus_do",    i, bus_do[i],        8'h00);
      chk("rst_rsp_valid", i, 8'(rsp_valid[i]), 8'h00);
      chk("rst_rsp_data",  i, rsp_data[i],      8'h00);
      chk("rst_err",       i, 8'(err[i]),       8'h00);
    end
  endtask

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int i = 0; i < 2; i++) begin
      sel_valid_m[i] = 1'b0;
      cur_chip_m[i]  = 1'b0;
      cur_fm_m[i]    = 1'b0;
      last_rsp_m[i]  = 8'h00;
      req_valid[i]   = 1'b0;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET  = 1'b1;
    pend_v = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rand_en[i] = 1'b0;
      req_rd[i] = 1'b0; req_chip[i] = 1'b0; req_fm[i] = 1'b0;
      req_addr[i] = 8'h00; req_data[i] = 8'h00; bus_di[i] = 8'h00;
    end
    model_reset();
    #1;
    chk_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET      = 1'b0;
    rand_en[1] = 1'b1;

    // Write with select: FB select, address 07, data 38, ready 19 cycles after accept
    send(1'b0, 1'b1, 1'b1, 8'h07, 8'h38, 8'h00);
    chk("w1_len",    0, 8'(qa.size()), 8'd18);
    chk("w1_sel_do", 0, qa[0].dout, 8'hFB);
    chk("w1_gap_do", 0, 8'({qa[4].bdir, qa[4].bc}), 8'h0);
    chk("w1_wr_do",  0, qa[12].dout, 8'h38);
    chk("w1_wr_ctl", 0, 8'({qa[12].bdir, qa[12].bc}), 8'h2);
    drain(0);

    // Same chip/fm: no select, ready 13 cycles after accept
    send(1'b0, 1'b1, 1'b1, 8'h08, 8'h0F, 8'h00);
    chk("w2_len",     0, 8'(qa.size()), 8'd12);
    chk("w2_addr_do", 0, qa[0].dout, 8'h08);
    chk("w2_wr_do",   0, qa[6].dout, 8'h0F);
    drain(0);

    // Read chip 0, fm 0: select FE, BC-only phase, response 5A
    send(1'b1, 1'b0, 1'b0, 8'h0E, 8'h00, 8'h5A);
    chk("r_len",     0, 8'(qa.size()), 8'd19);
    chk("r_sel_do",  0, qa[0].dout, 8'hFE);
    chk("r_rd_ctl",  0, 8'({qa[12].bdir, qa[12].bc}), 8'h1);
    chk("r_rsp_v",   0, 8'(qa[18].rsp_v), 8'h1);
    chk("r_rsp_d",   0, qa[18].rsp_d, 8'h5A);
    drain(0);
    run(2);

    // Reserved address: one ERR pulse, no bus activity, still ready
    send(1'b0, 1'b0, 1'b0, 8'hF9, 8'h55, 8'h00);
    chk("bad_len",   0, 8'(qa.size()), 8'd1);
    chk("bad_err",   0, 8'(qa[0].err), 8'h1);
    chk("bad_ready", 0, 8'(qa[0].ready), 8'h1);
    drain(0);
    run(2);

    // Reset in the first WR cycle of a selected write, then the same chip selects again
    send(1'b0, 1'b1, 1'b1, 8'h21, 8'h5C, 8'h00);
    chk("w3_len", 0, 8'(qa.size()), 8'd18);
    run(13);
    chk("w3_in_wr", 0, 8'({bdir[0], bc[0]}), 8'h2);
    RESET = 1'b1;
    #1;
    chk_reset();
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    send(1'b0, 1'b1, 1'b1, 8'h07, 8'h11, 8'h00);
    chk("w4_len",    0, 8'(qa.size()), 8'd18);
    chk("w4_sel_do", 0, qa[0].dout, 8'hFB);
    drain(0);

    // Random traffic on both instances
    rand_en[0] = 1'b1;
    run(3000);
    rand_en[0] = 1'b0;
    rand_en[1] = 1'b0;
    drain(0);
    drain(1);
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ay_bus_master.md
AY_BUS_MASTER -- requirements
Module: ay_bus_master

Interface
REQ-001 SHALL have parameter PHASE_CYC, default 4: number of CLK cycles each active bus phase is held (legal 1..255).
REQ-002 SHALL have parameter GAP_CYC, default 2: number of idle cycles (BDIR=0, BC=0) after every active phase (legal 1..255).
REQ-003 CLK  in  1  system clock; all state changes on its rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-high.
REQ-005 REQ_VALID  in  1  request present.
REQ-006 REQ_READY  out  1  block accepts a request this cycle; a request transfers when REQ_VALID & REQ_READY.
REQ-007 REQ_RD  in  1  1 = register read, 0 = register write.
REQ-008 REQ_CHIP  in  1  target chip, 0 or 1; 1 is driven as select bit 0 = 1.
REQ-009 REQ_FM  in  1  FM enable requested for the target.
REQ-010 REQ_ADDR  in  8  register address.
REQ-011 REQ_DATA  in  8  write data; ignored for reads.
REQ-012 RSP_VALID  out  1  one-cycle pulse carrying read data.
REQ-013 RSP_DATA  out  8  read data; held until the next read completes.
REQ-014 ERR  out  1  one-cycle pulse for a rejected request.
REQ-015 BDIR, BC  out  1 each  AY bus control outputs.
REQ-016 BUS_DO  out  8  data driven to the device DI.
REQ-017 BUS_DI  in  8  data returned from the device DO.
REQ-018 BUSY  out  1  equals ~REQ_READY.

Function
REQ-019 The block SHALL implement this FSM: IDLE, SEL, ADDR, WR, RD, GAP, RESP. REQ_READY=1 only in IDLE. Each request is latched on accept; there is no queue.
REQ-020 The block SHALL hold internal state cur_chip, cur_fm, and sel_valid (sel_valid=0 after reset).
REQ-021 Accept with REQ_ADDR[7:3]==5'b11111: the block SHALL pulse ERR next cycle, generate no bus activity, and stay in IDLE.
REQ-022 Accept with sel_valid=0 or {REQ_CHIP,REQ_FM}!={cur_chip,cur_fm}: the block SHALL go to SEL, then ADDR. Otherwise it SHALL go directly to ADDR.
REQ-023 SEL SHALL drive BDIR=1, BC=1, BUS_DO={5'b11111, ~fm, 1'b1, chip} for PHASE_CYC cycles. On exit it SHALL update cur_chip and cur_fm and set sel_valid.
REQ-024 ADDR SHALL drive BDIR=1, BC=1, BUS_DO=addr for PHASE_CYC cycles.
REQ-025 WR SHALL drive BDIR=1, BC=0, BUS_DO=data for PHASE_CYC cycles.
REQ-026 RD SHALL drive BDIR=0, BC=1, BUS_DO=8'h00 for PHASE_CYC cycles. BUS_DI SHALL be sampled at the last RD cycle.
REQ-027 Each of SEL, ADDR, WR, and RD SHALL be followed by GAP: BDIR=0, BC=0, BUS_DO=8'h00 for GAP_CYC cycles. This guarantees a BDIR rising edge per phase.
REQ-028 GAP SHALL continue as follows: after SEL to ADDR; after ADDR to WR or RD; after WR to IDLE; after RD to RESP.
REQ-029 RESP SHALL last one cycle with RSP_VALID=1 and RSP_DATA=sampled value, then return to IDLE.
REQ-030 BDIR, BC, and BUS_DO SHALL be registered outputs, glitch-free, and SHALL change only on state or phase boundaries.
REQ-031 The phase counter SHALL be 8 bits, load PHASE_CYC-1 or GAP_CYC-1, and decrement to 0 with no wrap.
REQ-032 Write latency without select, accept at cycle T: ADDR occupies T+1..T+P; WR occupies T+P+G+1..T+2P+G; REQ_READY=1 again at T+2P+2G+1.
REQ-033 A select adds P+G cycles before ADDR. A read response pulses at T+2P+2G+1 and REQ_READY=1 at T+2P+2G+2.
REQ-034 REQ_VALID while busy SHALL be ignored, and the request inputs SHALL be don't-care outside the accept cycle.

Reset
REQ-035 While RESET is asserted, the block SHALL immediately set: BDIR=0, BC=0, BUS_DO=0, RSP_VALID=0, RSP_DATA=0, ERR=0, REQ_READY=0, state=IDLE, sel_valid=0, counter=0.
REQ-036 After RESET deasserts, REQ_READY SHALL be 1 on the first CLK edge.
REQ-037 Reset mid-operation SHALL abort the phase, drop the latched request, produce no RSP_VALID, and force a fresh select on the next request.

Verification
REQ-038 After reset, write chip=1, fm=1, addr=0x07, data=0x38 (P=4, G=2): bus shows 4 cycles BDIR/BC=11 with DO=0xFB, 2 idle, 4 cycles 11 with DO=0x07, 2 idle, 4 cycles 10 with DO=0x38, 2 idle; READY at T+19.
REQ-039 A second write with the same chip/fm, addr=0x08, data=0x0F: no select phase; READY at T+13.
REQ-040 Read chip=0, fm=0, addr=0x0E with BUS_DI=0x5A: select DO=0xFE, address phase, then 4 cycles BC-only; RSP_VALID pulses once with RSP_DATA=0x5A.
REQ-041 Request with addr=0xF9: ERR pulses for 1 cycle; BDIR and BC stay 0; REQ_READY remains 1.
REQ-042 RESET asserted during the WR phase: outputs go to 0 asynchronously; the next write with the same chip re-issues the select phase.
REQ-043 With P=1, G=1, back-to-back writes with REQ_VALID held high: every active phase is exactly 1 cycle, separated by one idle cycle; no request is lost or duplicated.
